mem_wb_elastic_reg: RTL and testbench

- Parametrised successor of the MEM/WB pipeline register: a 2-entry elastic (skid-buffered) register between the MEM and WB stages.
- Adds valid/ready handshake, stall and flush support, and $0 write suppression.
- Resolves the writeback mux (MemtoReg) and exports a forwarding tap for the hazard unit.
- Sits between data-memory output and register-file write port.

---
 rtl/mem_wb_pkg.sv | 33 +++
 rtl/pipe_slot.sv | 20 ++
 rtl/mem_wb_elastic_reg.sv | 149 ++++++++++++++
 tb/tb_mem_wb_elastic_reg.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM/WB elastic register: control-bit positions, occupancy FSM states, default payload layout.
// No logic; no latency or backpressure of its own.
package mem_wb_pkg;

    localparam int WB_REGWRITE_BIT = 0;
    localparam int WB_MEMTOREG_BIT = 1;
    localparam int WB_CTRL_W       = 2;

    localparam int PKG_DATA_W     = 32;
    localparam int PKG_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } slot_state_t;

    typedef struct packed {
        logic [PKG_DATA_W-1:0]     rd;
        logic [PKG_DATA_W-1:0]     alu;
        logic [PKG_REG_ADDR_W-1:0] wr;
        logic [WB_CTRL_W-1:0]      ctrl;
    } mem_wb_payload_t;

    function automatic logic [1:0] state_occupancy(input slot_state_t s);
        case (s)
            ONE:     return 2'd1;
            TWO:     return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// Load-enabled payload register with synchronous reset to zero.
// Latency: 1 cycle from ld to q; no backpressure, the owner decides when to load.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (ld)
            q <= d;
    end

endmodule

// File: rtl/mem_wb_elastic_reg.sv
// MEM/WB elastic register: main + optional skid slot, resolves the writeback mux and feeds the forwarding tap.
// Latency: 1 cycle; backpressure: in_ready registered (state != TWO) with SKID=1, combinational !out_valid|out_ready with SKID=0.
module mem_wb_elastic_reg
    import mem_wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int SKID       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     RD_M,
    input  logic [DATA_W-1:0]     Alu_Result_M,
    input  logic [REG_ADDR_W-1:0] WR_M,
    input  logic [1:0]            WB_Control,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     RD,
    output logic [DATA_W-1:0]     Alu_Result,
    output logic [REG_ADDR_W-1:0] WR,
    output logic                  RegWrite,
    output logic                  MemtoReg,
    output logic [DATA_W-1:0]     WB_Data,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [1:0]            occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0]     rd;
        logic [DATA_W-1:0]     alu;
        logic [REG_ADDR_W-1:0] wr;
        logic [WB_CTRL_W-1:0]  ctrl;
    } payload_t;

    slot_state_t state_q, state_d;
    payload_t    in_pl, main_d, main_q, skid_q;
    logic        main_ld, skid_ld;
    logic        accept, pop, head_writes;

    always_comb begin
        in_pl      = '0;
        in_pl.rd   = RD_M;
        in_pl.alu  = Alu_Result_M;
        in_pl.wr   = WR_M;
        in_pl.ctrl = WB_Control;
    end

    pipe_slot #(.W($bits(payload_t))) u_main (
        .clk (clk),
        .rst (rst),
        .ld  (main_ld),
        .d   (main_d),
        .q   (main_q)
    );

    pipe_slot #(.W($bits(payload_t))) u_skid (
        .clk (clk),
        .rst (rst),
        .ld  (skid_ld),
        .d   (in_pl),
        .q   (skid_q)
    );

    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // With SKID=0 in_ready already includes out_ready, so ONE never sees accept without pop.
    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;
            always_ff @(posedge clk) begin
                if (rst)
                    in_ready_q <= 1'b1;
                else
                    in_ready_q <= (state_d != TWO);
            end
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign in_ready = !out_valid | out_ready;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
        skid_ld = 1'b0;
        main_d  = in_pl;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_ld = 1'b1;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    state_d = TWO;
                    skid_ld = 1'b1;
                end else if (pop && !accept) begin
                    state_d = EMPTY;
                end else if (accept && pop) begin
                    main_ld = 1'b1;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    main_ld = 1'b1;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush only drops the valid state; stale payload is never observed as valid.
        if (flush) begin
            state_d = EMPTY;
            main_ld = 1'b0;
            skid_ld = 1'b0;
        end
    end

    always_comb begin
        occupancy   = state_occupancy(state_q);
        RD          = main_q.rd;
        Alu_Result  = main_q.alu;
        WR          = main_q.wr;
        MemtoReg    = main_q.ctrl[WB_MEMTOREG_BIT];
        WB_Data     = main_q.ctrl[WB_MEMTOREG_BIT] ? main_q.rd : main_q.alu;
        head_writes = main_q.ctrl[WB_REGWRITE_BIT] && (main_q.wr != '0);
        fwd_valid   = out_valid & head_writes;
        RegWrite    = out_valid & out_ready & head_writes;
        fwd_addr    = main_q.wr;
        fwd_data    = WB_Data;
    end

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
module tb_mem_wb_elastic_reg;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // SKID=1 instance
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] rd_m, alu_m, rd, alu, wb_data, fwd_data;
    logic [4:0]  wr_m, wr, fwd_addr;
    logic [1:0]  wb_ctrl, occupancy;
    logic        reg_write, mem_to_reg, fwd_valid;

    // SKID=0 instance
    logic        z_iv, z_ir, z_ov, z_ordy;
    logic [31:0] z_rd_m, z_alu_m, z_rd, z_alu, z_wbd, z_fdata;
    logic [4:0]  z_wr_m, z_wr, z_faddr;
    logic [1:0]  z_ctrl, z_occ;
    logic        z_rw, z_m2r, z_fv;

    mem_wb_elastic_reg #(.DATA_W(32), .REG_ADDR_W(5), .SKID(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .RD_M(rd_m), .Alu_Result_M(alu_m), .WR_M(wr_m), .WB_Control(wb_ctrl),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .RD(rd), .Alu_Result(alu), .WR(wr), .RegWrite(reg_write), .MemtoReg(mem_to_reg),
        .WB_Data(wb_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .occupancy(occupancy)
    );

    mem_wb_elastic_reg #(.DATA_W(32), .REG_ADDR_W(5), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(z_iv), .in_ready(z_ir),
        .RD_M(z_rd_m), .Alu_Result_M(z_alu_m), .WR_M(z_wr_m), .WB_Control(z_ctrl),
        .flush(1'b0), .out_valid(z_ov), .out_ready(z_ordy),
        .RD(z_rd), .Alu_Result(z_alu), .WR(z_wr), .RegWrite(z_rw), .MemtoReg(z_m2r),
        .WB_Data(z_wbd), .fwd_valid(z_fv), .fwd_addr(z_faddr), .fwd_data(z_fdata),
        .occupancy(z_occ)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        iv, ordy, fl;
        logic [31:0] rd, alu;
        logic [4:0]  wr;
        logic [1:0]  ctrl;
        logic        chk_pl;
        logic        e_ov;
        logic [1:0]  e_occ;
        logic        e_ir, e_rw, e_fv;
        logic [4:0]  e_wr;
        logic [31:0] e_wbd;
    } vec_t;

    typedef struct packed {
        logic [31:0] rd, alu;
        logic [4:0]  wr;
        logic [1:0]  ctrl;
    } pl_t;

    function automatic vec_t mk(input logic iv, ordy, fl, input logic [31:0] d_rd, d_alu,
                                input logic [4:0] d_wr, input logic [1:0] d_ctrl, input logic cp,
                                input logic ov, input logic [1:0] occ, input logic ir, rw, fv,
                                input logic [4:0] ewr, input logic [31:0] ewbd);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.rd = d_rd; v.alu = d_alu; v.wr = d_wr;
        v.ctrl = d_ctrl; v.chk_pl = cp; v.e_ov = ov; v.e_occ = occ; v.e_ir = ir;
        v.e_rw = rw; v.e_fv = fv; v.e_wr = ewr; v.e_wbd = ewbd;
        return v;
    endfunction

    task automatic drive(input logic iv, ordy, fl, input logic [31:0] d_rd, d_alu,
                         input logic [4:0] d_wr, input logic [1:0] d_ctrl);
        in_valid = iv; out_ready = ordy; flush = fl;
        rd_m = d_rd; alu_m = d_alu; wr_m = d_wr; wb_ctrl = d_ctrl;
    endtask

    vec_t tv[14];
    pl_t  q[$];
    pl_t  p;

    initial begin
        // Each row: inputs held for one cycle, outputs compared just before the edge that consumes them.
        tv[0]  = mk(1,1,0, 32'hDEADBEEF, 32'h10, 8, 2'b11, 1, 0,0,1,0,0, 0, 32'h0);
        tv[1]  = mk(0,1,0, 32'h0, 32'h0, 0, 2'b00, 1, 1,1,1,1,1, 8, 32'hDEADBEEF);
        tv[2]  = mk(1,0,0, 32'h111, 32'hA0, 3, 2'b01, 0, 0,0,1,0,0, 0, 32'h0);
        tv[3]  = mk(1,0,0, 32'h222, 32'hB0, 4, 2'b11, 1, 1,1,1,0,1, 3, 32'hA0);
        tv[4]  = mk(1,0,0, 32'h999, 32'hC0, 5, 2'b11, 1, 1,2,0,0,1, 3, 32'hA0);
        tv[5]  = mk(0,1,0, 32'h0, 32'h0, 0, 2'b00, 1, 1,2,0,1,1, 3, 32'hA0);
        tv[6]  = mk(0,1,0, 32'h0, 32'h0, 0, 2'b00, 1, 1,1,1,1,1, 4, 32'h222);
        tv[7]  = mk(1,0,0, 32'h333, 32'h5, 0, 2'b01, 0, 0,0,1,0,0, 0, 32'h0);
        tv[8]  = mk(0,1,0, 32'h0, 32'h0, 0, 2'b00, 1, 1,1,1,0,0, 0, 32'h5);
        tv[9]  = mk(1,0,0, 32'h44, 32'h40, 9, 2'b01, 0, 0,0,1,0,0, 0, 32'h0);
        tv[10] = mk(1,0,0, 32'h55, 32'h50, 10, 2'b01, 1, 1,1,1,0,1, 9, 32'h40);
        tv[11] = mk(1,0,1, 32'h66, 32'h60, 11, 2'b01, 1, 1,2,0,0,1, 9, 32'h40);
        tv[12] = mk(0,1,0, 32'h0, 32'h0, 0, 2'b00, 0, 0,0,1,0,0, 0, 32'h0);
        tv[13] = mk(0,1,0, 32'h0, 32'h0, 0, 2'b00, 0, 0,0,1,0,0, 0, 32'h0);

        rst = 1'b1;
        drive(0,0,0, 32'h0, 32'h0, 0, 2'b00);
        z_iv = 0; z_ordy = 0; z_rd_m = 0; z_alu_m = 0; z_wr_m = 0; z_ctrl = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            if (i != 0) @(negedge clk);
            drive(tv[i].iv, tv[i].ordy, tv[i].fl, tv[i].rd, tv[i].alu, tv[i].wr, tv[i].ctrl);
            #2;
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tv[i].e_ov));
            chk($sformatf("row%0d occupancy", i), 32'(occupancy), 32'(tv[i].e_occ));
            chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tv[i].e_ir));
            chk($sformatf("row%0d RegWrite", i), 32'(reg_write), 32'(tv[i].e_rw));
            chk($sformatf("row%0d fwd_valid", i), 32'(fwd_valid), 32'(tv[i].e_fv));
            if (tv[i].chk_pl) begin
                chk($sformatf("row%0d WR", i), 32'(wr), 32'(tv[i].e_wr));
                chk($sformatf("row%0d fwd_addr", i), 32'(fwd_addr), 32'(tv[i].e_wr));
                chk($sformatf("row%0d WB_Data", i), wb_data, tv[i].e_wbd);
                chk($sformatf("row%0d fwd_data", i), fwd_data, tv[i].e_wbd);
            end
        end

        // Streaming: accept and pop together in ONE, one entry per cycle, ALU result selected.
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            drive(i < 10, 1, 0, 32'hFFFF0000 + 32'(i), 32'h100 + 32'(i), 5'(i + 1), 2'b01);
            #2;
            if (i > 0) begin
                chk($sformatf("stream%0d out_valid", i), 32'(out_valid), 32'd1);
                chk($sformatf("stream%0d occupancy", i), 32'(occupancy), 32'd1);
                chk($sformatf("stream%0d WR", i), 32'(wr), 32'(i));
                chk($sformatf("stream%0d WB_Data", i), wb_data, 32'h100 + 32'(i - 1));
                chk($sformatf("stream%0d MemtoReg", i), 32'(mem_to_reg), 32'd0);
                chk($sformatf("stream%0d RegWrite", i), 32'(reg_write), 32'd1);
            end
        end
        @(negedge clk);
        drive(0,1,0, 32'h0, 32'h0, 0, 2'b00);
        #2;
        chk("stream drained out_valid", 32'(out_valid), 32'd0);

        // Reset while holding two entries.
        @(negedge clk);
        drive(1,0,0, 32'hAAAA0001, 32'h1001, 1, 2'b11);
        @(negedge clk);
        drive(1,0,0, 32'hAAAA0002, 32'h1002, 2, 2'b11);
        @(negedge clk);
        drive(0,0,0, 32'h0, 32'h0, 0, 2'b00);
        #2;
        chk("pre-reset occupancy", 32'(occupancy), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        drive(1,1,0, 32'hBBBB0003, 32'h1003, 3, 2'b11);
        @(negedge clk);
        rst = 1'b0;
        drive(0,1,0, 32'h0, 32'h0, 0, 2'b00);
        #2;
        chk("rst occupancy", 32'(occupancy), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst RD", rd, 32'h0);
        chk("rst Alu_Result", alu, 32'h0);
        chk("rst WR", 32'(wr), 32'd0);
        chk("rst WB_Data", wb_data, 32'h0);
        chk("rst RegWrite", 32'(reg_write), 32'd0);
        chk("rst fwd_valid", 32'(fwd_valid), 32'd0);
        chk("rst MemtoReg", 32'(mem_to_reg), 32'd0);

        // SKID=0 instance against a reference queue.
        for (int c = 0; c < 1000; c++) begin
            logic e_ov, e_ir;
            @(negedge clk);
            z_iv = 1'($urandom_range(0, 1));
            z_ordy = 1'($urandom_range(0, 1));
            z_rd_m = $urandom;
            z_alu_m = $urandom;
            z_wr_m = 5'($urandom_range(0, 31));
            z_ctrl = 2'($urandom_range(0, 3));
            #2;
            e_ov = (q.size() != 0);
            e_ir = !e_ov || z_ordy;
            chk($sformatf("s0 c%0d out_valid", c), 32'(z_ov), 32'(e_ov));
            chk($sformatf("s0 c%0d in_ready", c), 32'(z_ir), 32'(e_ir));
            chk($sformatf("s0 c%0d occupancy", c), 32'(z_occ), 32'(q.size()));
            if (e_ov) begin
                chk($sformatf("s0 c%0d WR", c), 32'(z_wr), 32'(q[0].wr));
                chk($sformatf("s0 c%0d WB_Data", c), z_wbd, q[0].ctrl[1] ? q[0].rd : q[0].alu);
                chk($sformatf("s0 c%0d RegWrite", c), 32'(z_rw),
                    32'(z_ordy && q[0].ctrl[0] && (q[0].wr != 0)));
            end
            if (e_ov && z_ordy) void'(q.pop_front());
            if (z_iv && e_ir) begin
                p.rd = z_rd_m; p.alu = z_alu_m; p.wr = z_wr_m; p.ctrl = z_ctrl;
                q.push_back(p);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
